// File: rtl/line_buffer_pkg.sv
// Shared CNN definitions used by the line buffer and the downstream window stage.
// Column-slice convention: in a packed column of KERNEL_HEIGHT pixels, slice i occupies
// bits [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] and carries image row r-(KERNEL_HEIGHT-1)+i,
// so the highest slice is the newest (current) row.
package line_buffer_pkg;

    localparam int unsigned DataWidthDef    = 16;
    localparam int unsigned KernelWidthDef  = 3;
    localparam int unsigned KernelHeightDef = 3;

    // True when slice 'slice' of a column taken at image row 'row' lies above the image.
    // Written as a sum to avoid unsigned underflow of kh-1-slice.
    function automatic logic slice_is_pad(input int unsigned row, input int unsigned slice,
                                          input int unsigned kh);
        return (row + slice) < (kh - 1);
    endfunction

endpackage

// File: rtl/line_buffer_line_ram.sv
// line_ram: DEPTH x DATA_WIDTH line memory with a registered read.
// A read and a write may target the same address on the same edge; the read returns the
// old contents.
// Ports:
//   clk   - clock
//   re    - read enable; rdata holds when low
//   raddr - read address
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   rdata - registered read data
module line_ram #(
    parameter int unsigned DEPTH      = 28,
    parameter int unsigned DATA_WIDTH = 16,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/line_buffer.sv
// line_buffer: raster-to-column converter feeding the convolution window stage.
// Each accepted pixel produces one packed column of KERNEL_HEIGHT pixels taken from the
// current row and the previous KERNEL_HEIGHT-1 rows; rows above the image read as 0.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous active-high reset (wins over pix_valid)
//   pix_in     - input pixel, row-major
//   pix_valid  - pixel strobe, always accepted
//   col_out    - packed column, slice KERNEL_HEIGHT-1 = current pixel
//   col_valid  - one-cycle pulse per accepted pixel
//   win_valid  - with col_valid: column completes a full in-image window
//   frame_done - with col_valid: column belongs to the last pixel of the frame
module line_buffer
    import line_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DataWidthDef,
    parameter int unsigned KERNEL_WIDTH  = KernelWidthDef,
    parameter int unsigned KERNEL_HEIGHT = KernelHeightDef,
    parameter int unsigned IMAGE_WIDTH   = 28,
    parameter int unsigned IMAGE_HEIGHT  = 28
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              pix_in,
    input  logic                               pix_valid,
    output logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_out,
    output logic                               col_valid,
    output logic                               win_valid,
    output logic                               frame_done
);

    localparam int unsigned CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int unsigned RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
    localparam int unsigned NL = KERNEL_HEIGHT - 1;

    localparam logic [CW-1:0] ColLast = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMAGE_HEIGHT - 1);

    logic                  accept;
    logic [CW-1:0]         col_cnt_q;
    logic [RW-1:0]         row_cnt_q;

    // Stage 1: pixel and position alongside the registered line-memory reads.
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] s1_pix_q;
    logic [CW-1:0]         s1_col_q;
    logic [RW-1:0]         s1_row_q;

    logic [DATA_WIDTH-1:0] rd [NL];

    logic [KERNEL_HEIGHT*DATA_WIDTH-1:0] col_d;
    logic                                win_d;
    logic                                frame_d;

    assign accept = pix_valid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
        end else if (pix_valid) begin
            if (col_cnt_q == ColLast) begin
                col_cnt_q <= '0;
                row_cnt_q <= (row_cnt_q == RowLast) ? '0 : row_cnt_q + 1'b1;
            end else begin
                col_cnt_q <= col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= pix_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1_pix_q <= pix_in;
            s1_col_q <= col_cnt_q;
            s1_row_q <= row_cnt_q;
        end
    end

    // Each line memory is read at column c on the accept edge; the row shift (memory k
    // takes the old memory k+1 value) is written back on the following edge from those
    // registered reads. The next access to column c is a full row later, so the deferred
    // write never races a read of the same column.
    for (genvar k = 0; k < NL; k++) begin : g_line
        logic [DATA_WIDTH-1:0] wdata;
        if (k == NL - 1) begin : g_newest
            assign wdata = s1_pix_q;
        end else begin : g_chain
            assign wdata = rd[k+1];
        end

        line_ram #(
            .DEPTH      (IMAGE_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_ram (
            .clk   (clk),
            .re    (accept),
            .raddr (col_cnt_q),
            .we    (s1_valid_q),
            .waddr (s1_col_q),
            .wdata (wdata),
            .rdata (rd[k])
        );
    end

    // Padding masks memory slices above the image, so stale memory content from a
    // previous frame or an interrupted frame never reaches the output.
    always_comb begin
        col_d = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (!slice_is_pad(32'(s1_row_q), i, KERNEL_HEIGHT)) begin
                col_d[i*DATA_WIDTH +: DATA_WIDTH] = rd[i];
            end
        end
        col_d[NL*DATA_WIDTH +: DATA_WIDTH] = s1_pix_q;
        win_d   = (32'(s1_row_q) >= KERNEL_HEIGHT - 1) && (32'(s1_col_q) >= KERNEL_WIDTH - 1);
        frame_d = (s1_row_q == RowLast) && (s1_col_q == ColLast);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_out    <= '0;
            col_valid  <= 1'b0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            col_valid  <= s1_valid_q;
            win_valid  <= s1_valid_q & win_d;
            frame_done <= s1_valid_q & frame_d;
            if (s1_valid_q) begin
                col_out <= col_d;
            end
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Scoreboard bench for line_buffer with a 4x3 image and a 3x3 kernel.
module tb_line_buffer;

    localparam int DW = 16;
    localparam int KH = 3;
    localparam int IW = 4;
    localparam int IH = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [DW-1:0]    pix_in = '0;
    logic             pix_valid = 1'b0;
    logic [KH*DW-1:0] col_out;
    logic             col_valid;
    logic             win_valid;
    logic             frame_done;

    line_buffer #(
        .DATA_WIDTH    (DW),
        .KERNEL_WIDTH  (3),
        .KERNEL_HEIGHT (KH),
        .IMAGE_WIDTH   (IW),
        .IMAGE_HEIGHT  (IH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .col_out    (col_out),
        .col_valid  (col_valid),
        .win_valid  (win_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KH*DW-1:0] col;
        logic             win;
        logic             fd;
    } exp_t;

    exp_t          sb_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;
    int            win_in_frame = 0;
    logic [KH*DW-1:0] last_exp = '0;

    // Reference image of the current frame and its write position.
    logic [DW-1:0] img [IH][IW];
    int            mr = 0;
    int            mc = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [DW-1:0] p);
        exp_t e;
        img[mr][mc] = p;
        e.col = '0;
        for (int i = 0; i < KH; i++) begin
            int rr = mr - (KH - 1) + i;
            if (rr >= 0) e.col[i*DW +: DW] = img[rr][mc];
        end
        e.win = (mr >= 2) && (mc >= 2);
        e.fd  = (mr == IH - 1) && (mc == IW - 1);
        sb_q.push_back(e);
        if (mc == IW - 1) begin
            mc = 0;
            mr = (mr == IH - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] p, input logic r);
        @(negedge clk);
        reset     = r;
        pix_valid = v;
        pix_in    = p;
        if (r) begin
            // Any column still in flight is killed by the reset edge.
            sb_q.delete();
            mr = 0;
            mc = 0;
        end else if (v) begin
            model_accept(p);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        check_eq("drain_pending", 64'(sb_q.size()), 64'd0);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        exp_t e;
        logic rs;
        forever begin
            @(posedge clk);
            rs = reset;
            #1;
            if (rs) begin
                check_eq("rst_col_out", 64'(col_out), 64'd0);
                check_eq("rst_col_valid", 64'(col_valid), 64'd0);
                check_eq("rst_win_valid", 64'(win_valid), 64'd0);
                check_eq("rst_frame_done", 64'(frame_done), 64'd0);
                last_exp     = '0;
                win_in_frame = 0;
            end else if (col_valid) begin
                n_out++;
                check_eq("col_without_pixel", 64'(sb_q.size() == 0), 64'd0);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("col_out", 64'(col_out), 64'(e.col));
                    check_eq("win_valid", 64'(win_valid), 64'(e.win));
                    check_eq("frame_done", 64'(frame_done), 64'(e.fd));
                    last_exp = e.col;
                end
                if (win_valid) win_in_frame++;
                if (frame_done) begin
                    check_eq("win_per_frame", 64'(win_in_frame), 64'd2);
                    win_in_frame = 0;
                end
            end else begin
                check_eq("hold_col_out", 64'(col_out), 64'(last_exp));
                check_eq("idle_win_valid", 64'(win_valid), 64'd0);
                check_eq("idle_frame_done", 64'(frame_done), 64'd0);
            end
        end
    end

    initial begin
        int acc;
        int out0;

        step(0, '0, 1);
        step(0, '0, 1);

        // Frame 0 and a back-to-back frame 1 offset by 0x100, continuous.
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < IH; r++)
                for (int c = 0; c < IW; c++)
                    step(1, DW'(f * 16'h100 + 16 * r + c), 0);
        step(0, '0, 0);
        drain();

        // Frame 2 with random gaps, same raster pattern offset by 0x200.
        acc  = 0;
        out0 = n_out;
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                while ($urandom_range(1, 0) == 0) step(0, DW'($urandom), 0);
                step(1, DW'(16'h200 + 16 * r + c), 0);
                acc++;
            end
        step(0, '0, 0);
        drain();
        check_eq("gap_col_valid_count", 64'(n_out - out0), 64'(acc));

        // Reset after pixel (1,1): next pixel restarts at (0,0) with full padding.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW && !(r == 1 && c > 1); c++)
                step(1, DW'(16 * r + c), 0);
        step(0, '0, 1);
        step(1, 16'hAAAA, 0);
        step(0, '0, 0);
        drain();

        // Reset together with pix_valid: pixel dropped, counters stay at (0,0).
        step(1, 16'h5555, 1);
        step(0, '0, 0);
        @(posedge clk);
        #2;
        check_eq("rst_drop_col_valid", 64'(col_valid), 64'd0);
        step(1, 16'h1234, 0);
        step(1, 16'h1235, 0);
        step(0, '0, 0);
        drain();

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_buffer.md
# line_buffer

Raster-to-column converter that sits directly upstream of the convolution sliding-window stage. It accepts one pixel per cycle in row-major order and stores the previous KERNEL_HEIGHT-1 image rows in on-chip line memories. For each accepted pixel it emits a packed vertical column of KERNEL_HEIGHT pixels, the format the window stage shifts in every cycle. It also flags when the downstream window holds a fully valid KERNEL_WIDTH x KERNEL_HEIGHT neighbourhood.

## Interface
- DATA_WIDTH, 16, pixel width in bits
- KERNEL_WIDTH, 3, kernel columns; used only for win_valid
- KERNEL_HEIGHT, 3, kernel rows; number of pixels per output column (>=2)
- IMAGE_WIDTH, 28, pixels per row (>=KERNEL_WIDTH)
- IMAGE_HEIGHT, 28, rows per frame (>=KERNEL_HEIGHT)

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pix_in  in  DATA_WIDTH  input pixel, row-major
- pix_valid  in  1  pix_in is valid this cycle; there is no backpressure, so every valid pixel is accepted
- col_out  out  KERNEL_HEIGHT*DATA_WIDTH  packed column; slice [(i+1)*DATA_WIDTH-1 -: DATA_WIDTH] is row r-(KERNEL_HEIGHT-1)+i, so slice KERNEL_HEIGHT-1 is the current pixel
- col_valid  out  1  col_out is updated this cycle (1-cycle pulse per accepted pixel)
- win_valid  out  1  with col_valid: the column completes a full in-image window
- frame_done  out  1  with col_valid: the column is for the last pixel of the frame

## Operation
- Counters: col_cnt 0..IMAGE_WIDTH-1 and row_cnt 0..IMAGE_HEIGHT-1 advance only on accepted pixels.
  - col_cnt wraps to 0 at IMAGE_WIDTH-1 and increments row_cnt.
  - row_cnt wraps to 0 after the last pixel of a frame, so the next frame starts immediately with no idle cycle.
- Line memories: KERNEL_HEIGHT-1 memories, each IMAGE_WIDTH x DATA_WIDTH, addressed by col_cnt. Memory k holds row r-(KERNEL_HEIGHT-1)+k.
- On an accept at (r,c):
  - Read all memories at c, read-before-write.
  - Write memory k with the old memory k+1 value for k < KERNEL_HEIGHT-2.
  - Write memory KERNEL_HEIGHT-2 with pix_in.
- Top padding: column slice i is forced to 0 when r < KERNEL_HEIGHT-1-i. Memories are never cleared, and stale content must never reach col_out.
- Flags:
  - win_valid = (r >= KERNEL_HEIGHT-1) && (c >= KERNEL_WIDTH-1).
  - frame_done = (r == IMAGE_HEIGHT-1) && (c == IMAGE_WIDTH-1).
- Data passes through untouched; there is no arithmetic on pixel values.
- No pix_valid: counters, memories and col_out hold; col_valid, win_valid and frame_done are 0.
- Reset mid-frame: counters go to 0 on the reset cycle. The next accepted pixel is treated as (0,0) with full top padding. Memory contents are left as-is.

## Timing
- Reset values: col_out=0, col_valid=0, win_valid=0, frame_done=0, col_cnt=0, row_cnt=0.
- Latency: a pixel accepted at edge N appears on col_out with col_valid=1 after edge N+1. All outputs are registered.
- Throughput: one pixel per cycle sustained, including across row and frame boundaries.
- Memory timing: single-cycle read, read-old-data on same-address read/write.
- Reset asserted in the same cycle as pix_valid: reset wins, and the pixel is dropped.

## Structure
- The shared CNN package holds DATA_WIDTH and KERNEL_WIDTH/KERNEL_HEIGHT defaults and the column-slice index convention. The window stage uses the same convention.
- Counter widths are local: $clog2(IMAGE_WIDTH) and $clog2(IMAGE_HEIGHT).
- Sub-module line_ram: parameterised DEPTH x DATA_WIDTH, one read/write port, read-before-write, registered read. It is instantiated KERNEL_HEIGHT-1 times in a generate loop.

## Test plan
Common setup: DATA_WIDTH=16, KERNEL_HEIGHT=KERNEL_WIDTH=3, IMAGE_WIDTH=4, IMAGE_HEIGHT=3, pixel value = 16*r + c.

- **Frame 0, continuous pix_valid:**
  - First col_out = {0x0000, 0x0000, 0x0000} from top to bottom slice, i.e. slices 2,1,0 = 0x0000,0,0.
  - Pixel (1,2): slices 2,1,0 = 0x0012, 0x0002, 0x0000.
  - Pixel (2,3): slices = 0x0023, 0x0013, 0x0003, with win_valid=1 and frame_done=1.
- **win_valid count per frame:** exactly 2 pulses, at (2,2) and (2,3). No pulse at (2,0) or (2,1).
- **Back-to-back second frame with values +0x100:** first column is all padding (0x0100, 0, 0). No frame-0 data leaks.
- **Random pix_valid gaps (~50% duty):** col_out sequence is identical to the continuous case. col_valid count equals the accepted count. Outputs hold during gaps.
- **Reset asserted after pixel (1,1):**
  - All outputs are 0 on the next cycle.
  - The next pixel 0xAAAA yields col_out slices = 0xAAAA, 0, 0.
- **Reset and pix_valid in the same cycle:** no col_valid follows, and the counters remain at (0,0).
